// File: rtl/vga_timing_gen.sv
// Raster timing generator: col/row scan, registered valid/hsync/vsync and line/frame strobes.
// Defining VGA_FRAME_CNT_EN adds a 16-bit frame counter output (frame_cnt).
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned CLK_DIV   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic        pix_tick,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024) begin : g_chk_h
    $error("vga_timing_gen: H_TOTAL must not exceed 1024");
  end
  if (V_TOTAL > 1024) begin : g_chk_v
    $error("vga_timing_gen: V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic             valid_q, valid_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             tick_q, tick_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]      fcnt_q, fcnt_d;
`endif

  // Qualifiers are derived from the next col/row so they land in the same register stage.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    tick_d  = (div_q == DIV_LAST);
    div_d   = tick_d ? '0 : div_q + 1'b1;
    if (tick_d) begin
      col_d = (col_q == H_LAST) ? '0 : col_q + 1'b1;
      if (col_q == H_LAST) begin
        row_d = (row_q == V_LAST) ? '0 : row_q + 1'b1;
      end
      valid_d = ({1'b0, col_d} < H_VIS) && ({1'b0, row_d} < V_VIS);
      hsync_d = (({1'b0, col_d} >= HS_START) && ({1'b0, col_d} < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = (({1'b0, row_d} >= VS_START) && ({1'b0, row_d} < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end
    line_d  = tick_d && (col_d == '0);
    frame_d = line_d && (row_d == '0);
`ifdef VGA_FRAME_CNT_EN
    fcnt_d  = frame_d ? fcnt_q + 1'b1 : fcnt_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      col_q   <= H_LAST;
      row_q   <= V_LAST;
      valid_q <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      tick_q  <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      fcnt_q  <= '0;
`endif
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      tick_q  <= tick_d;
      line_q  <= line_d;
      frame_q <= frame_d;
`ifdef VGA_FRAME_CNT_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  assign col         = col_q;
  assign row         = row_q;
  assign valid       = valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_tick    = tick_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
`ifdef VGA_FRAME_CNT_EN
  assign frame_cnt   = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing instance plus a small CLK_DIV=2 active-high instance,
// both checked every clock against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int unsigned SH_V = 16, SH_F = 2, SH_S = 3, SH_B = 3;
  localparam int unsigned SV_V = 12, SV_F = 2, SV_S = 2, SV_B = 3;
  localparam int unsigned S_DIV = 2;
  localparam int unsigned S_HT = SH_V + SH_F + SH_S + SH_B;
  localparam int unsigned S_VT = SV_V + SV_F + SV_S + SV_B;

  typedef struct packed {
    logic [9:0]  col;
    logic [9:0]  row;
    logic        valid;
    logic        hs;
    logic        vs;
    logic        tick;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic r0_n = 1'b0, r1_n = 1'b0;
  logic [9:0] col0, row0, col1, row1;
  logic valid0, hs0, vs0, tick0, ls0, fs0;
  logic valid1, hs1, vs1, tick1, ls1, fs1;
  logic [15:0] fc0, fc1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned n0 = 0, n1 = 0;

  always #5 clk = ~clk;

  vga_timing_gen d0 (
    .clk(clk), .reset_n(r0_n), .col(col0), .row(row0), .valid(valid0),
    .hsync(hs0), .vsync(vs0), .pix_tick(tick0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
    .SYNC_POL(1'b1), .CLK_DIV(S_DIV)
  ) d1 (
    .clk(clk), .reset_n(r1_n), .col(col1), .row(row1), .valid(valid1),
    .hsync(hs1), .vsync(vs1), .pix_tick(tick1), .line_start(ls1), .frame_start(fs1)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc0 = '0;
  assign fc1 = '0;
`endif

  // Position after n clock edges since reset release: tick k = n/D lands on pixel (k-1) of the raster.
  function automatic obs_t model(int unsigned n, int unsigned d,
                                 int unsigned hv, int unsigned hf, int unsigned hsw, int unsigned hb,
                                 int unsigned vv, int unsigned vf, int unsigned vsw, int unsigned vb,
                                 bit pol);
    int unsigned ht, vt, k, p, c, r;
    obs_t e;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    e = '0;
    e.col = 10'(ht - 1);
    e.row = 10'(vt - 1);
    e.hs = ~pol;
    e.vs = ~pol;
    if (n == 0) return e;
    k = n / d;
    if (k == 0) return e;
    p = (k - 1) % (ht * vt);
    c = p % ht;
    r = p / ht;
    e.col   = 10'(c);
    e.row   = 10'(r);
    e.valid = (c < hv) && (r < vv);
    e.hs    = (c >= hv + hf && c < hv + hf + hsw) ? pol : ~pol;
    e.vs    = (r >= vv + vf && r < vv + vf + vsw) ? pol : ~pol;
    e.tick  = (n % d == 0);
    e.ls    = e.tick && (c == 0);
    e.fs    = e.tick && (p == 0);
`ifdef VGA_FRAME_CNT_EN
    e.fc    = 16'((k - 1) / (ht * vt) + 1);
`endif
    return e;
  endfunction

  function automatic obs_t exp0(int unsigned n);
    return model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic obs_t exp1(int unsigned n);
    return model(n, S_DIV, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, 1'b1);
  endfunction

  function automatic obs_t get0();
    return '{col: col0, row: row0, valid: valid0, hs: hs0, vs: vs0,
             tick: tick0, ls: ls0, fs: fs0, fc: fc0};
  endfunction

  function automatic obs_t get1();
    return '{col: col1, row: row1, valid: valid1, hs: hs1, vs: vs1,
             tick: tick1, ls: ls1, fs: fs1, fc: fc1};
  endfunction

  task automatic restart0();
    @(negedge clk);
    r0_n = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    r0_n = 1'b1;
    n0 = 0;
  endtask

  task automatic restart1();
    @(negedge clk);
    r1_n = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    r1_n = 1'b1;
    n1 = 0;
  endtask

  task automatic test_reset();
    obs_t first;
    @(negedge clk);
    #2 r0_n = 1'b0;
    #1;
    vectors++;
    if (get0() !== exp0(0)) begin
      miscompares++;
      $display("FAIL reset_async got=%h want=%h", get0(), exp0(0));
    end
    repeat ($urandom_range(2, 6)) @(negedge clk);
    vectors++;
    if (get0() !== exp0(0)) begin
      miscompares++;
      $display("FAIL reset_hold got=%h want=%h", get0(), exp0(0));
    end
    r0_n = 1'b1;
    n0 = 0;
    @(negedge clk);
    n0++;
    first = '{col: 10'd0, row: 10'd0, valid: 1'b1, hs: 1'b1, vs: 1'b1,
              tick: 1'b1, ls: 1'b1, fs: 1'b1, fc: 16'd0};
`ifdef VGA_FRAME_CNT_EN
    first.fc = 16'd1;
`endif
    vectors++;
    if (get0() !== first) begin
      miscompares++;
      $display("FAIL first_tick got=%h want=%h", get0(), first);
    end
  endtask

  task automatic test_line();
    int unsigned cycles, last_ls, have_ls, hs_low, vis;
    restart0();
    cycles = $urandom_range(2400, 3300);
    have_ls = 0; last_ls = 0; hs_low = 0; vis = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      n0++;
      vectors++;
      if (get0() !== exp0(n0)) begin
        miscompares++;
        $display("FAIL line_cycle n=%0d got=%h want=%h", n0, get0(), exp0(n0));
      end
      if (ls0 === 1'b1) begin
        if (have_ls != 0) begin
          vectors++;
          if (n0 - last_ls !== 800 || hs_low !== 96 || vis !== 640) begin
            miscompares++;
            $display("FAIL line_period got=%0d/%0d/%0d want=800/96/640", n0 - last_ls, hs_low, vis);
          end
        end
        have_ls = 1; last_ls = n0; hs_low = 0; vis = 0;
      end
      if (hs0 === 1'b0) hs_low++;
      if (valid0 === 1'b1) vis++;
    end
  endtask

  task automatic test_frame_div2();
    int unsigned cycles, lines, have_fs, last_fs, col_hold;
    logic [9:0] prev_col;
    restart1();
    cycles = 3 * S_HT * S_VT * S_DIV + $urandom_range(0, 200);
    lines = 0; have_fs = 0; last_fs = 0; col_hold = 0; prev_col = '0;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      n1++;
      vectors++;
      if (get1() !== exp1(n1)) begin
        miscompares++;
        $display("FAIL div2_cycle n=%0d got=%h want=%h", n1, get1(), exp1(n1));
      end
      if (n1 > 1 && col1 === prev_col) col_hold++;
      prev_col = col1;
      if (ls1 === 1'b1) lines++;
      if (fs1 === 1'b1) begin
        if (have_fs != 0) begin
          vectors++;
          if (lines - 1 !== S_VT || n1 - last_fs !== S_HT * S_VT * S_DIV) begin
            miscompares++;
            $display("FAIL frame_period got=%0d lines/%0d clks want=%0d/%0d",
                     lines - 1, n1 - last_fs, S_VT, S_HT * S_VT * S_DIV);
          end
        end
        have_fs = 1; last_fs = n1; lines = 1;
      end
    end
    vectors++;
    if (col_hold !== (cycles - 1) / 2) begin
      miscompares++;
      $display("FAIL div2_col_hold got=%0d want=%0d", col_hold, (cycles - 1) / 2);
    end
  endtask

  task automatic test_mid_reset();
    int unsigned target;
    obs_t tgt;
    restart0();
    target = $urandom_range(1, 3) * 800 + $urandom_range(0, 799) + 1;
    while (n0 < target) begin
      @(negedge clk);
      n0++;
      vectors++;
      if (get0() !== exp0(n0)) begin
        miscompares++;
        $display("FAIL pre_abort n=%0d got=%h want=%h", n0, get0(), exp0(n0));
      end
    end
    tgt = exp0(n0);
    #2 r0_n = 1'b0;
    #1;
    vectors++;
    if (get0() !== exp0(0)) begin
      miscompares++;
      $display("FAIL abort_async at=(%0d,%0d) got=%h want=%h", tgt.col, tgt.row, get0(), exp0(0));
    end
    repeat ($urandom_range(1, 5)) @(negedge clk);
    r0_n = 1'b1;
    n0 = 0;
    for (int unsigned i = 0; i < 900; i++) begin
      @(negedge clk);
      n0++;
      vectors++;
      if (get0() !== exp0(n0)) begin
        miscompares++;
        $display("FAIL post_abort n=%0d got=%h want=%h", n0, get0(), exp0(n0));
      end
    end
  endtask

  task automatic test_div2_reset_between_ticks();
    restart1();
    repeat ($urandom_range(5, 60)) begin
      @(negedge clk);
      n1++;
    end
    #2 r1_n = 1'b0;
    #1;
    vectors++;
    if (get1() !== exp1(0)) begin
      miscompares++;
      $display("FAIL div2_abort got=%h want=%h", get1(), exp1(0));
    end
    @(negedge clk);
    r1_n = 1'b1;
    n1 = 0;
    for (int unsigned i = 0; i < 2 * S_HT * S_DIV; i++) begin
      @(negedge clk);
      n1++;
      vectors++;
      if (get1() !== exp1(n1)) begin
        miscompares++;
        $display("FAIL div2_restart n=%0d got=%h want=%h", n1, get1(), exp1(n1));
      end
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt_wrap();
    int unsigned budget;
    restart1();
    repeat (S_DIV * 5) @(negedge clk);
    force d1.fcnt_q = 16'hFFFF;
    @(negedge clk);
    release d1.fcnt_q;
    vectors++;
    if (fc1 !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL frame_cnt_preset got=%h want=ffff", fc1);
    end
    budget = S_HT * S_VT * S_DIV + 10;
    while (fs1 !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    vectors++;
    if (budget == 0 || fc1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL frame_cnt_wrap got=%h budget=%0d want=0000", fc1, budget);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_frame_div2();
    test_mid_reset();
    test_div2_reset_between_ticks();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
